// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction memory writer.
// Collects program bytes from a valid/ready byte stream, packs them little-endian
// into 32-bit words and writes one word per WRITE cycle to sequential addresses
// starting at 0. The CPU is held via cpu_hold until the load completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one trailing byte after the last word is compared against the
//   XOR of all program bytes of the load; a mismatch raises err and keeps
//   cpu_hold asserted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, num_words    load request pulse and word count (clamped to DEPTH)
//   byte_in, byte_valid byte stream input
//   byte_ready          loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data instruction memory write port
//   busy, done          load in progress / load complete (level)
//   cpu_hold            CPU held in reset while 1
//   err                 checksum mismatch (0 when feature disabled)
//   word_count          words written in the current load
//
// state   | meaning
// IDLE    | after reset, waiting for start, CPU held
// RECV    | accepting bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CHK     | accepting the trailing checksum byte (feature only)
// DONE    | load complete, waiting for a new start
module inst_mem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_buf_q, word_buf_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [ADDR_W:0]   target_in;
  logic              byte_xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  assign target_in = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign byte_xfer = byte_valid && byte_ready_q;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    target_d     = target_q;
    word_count_d = word_count_q;
    byte_ready_d = byte_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d     = target_in;
          word_count_d = '0;
          byte_idx_d   = '0;
          done_d       = 1'b0;
          cpu_hold_d   = 1'b1;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_RECV;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
          err_d  = 1'b0;
          if (target_in == '0) state_d = S_CHK;
`else
          if (target_in == '0) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            cpu_hold_d   = 1'b0;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
          end
`endif
        end
      end
      S_RECV: begin
        if (byte_xfer) begin
          word_buf_d[8*byte_idx_q +: 8] = byte_in;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          if (byte_idx_q == 2'd3) begin
            // Fourth byte goes straight to the write register; no extra cycle.
            state_d      = S_WRITE;
            byte_ready_d = 1'b0;
            wr_en_d      = 1'b1;
            wr_addr_d    = word_count_q[ADDR_W-1:0];
            wr_data_d    = {byte_in, word_buf_q[23:0]};
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        byte_idx_d   = '0;
        if (word_count_d == target_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d      = S_CHK;
          byte_ready_d = 1'b1;
`else
          state_d      = S_DONE;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          cpu_hold_d   = 1'b0;
`endif
        end else begin
          state_d      = S_RECV;
          byte_ready_d = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (byte_xfer) begin
          err_d        = (byte_in != csum_q);
          state_d      = S_DONE;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          byte_ready_d = 1'b0;
          cpu_hold_d   = err_d;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      target_q     <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      target_q     <= target_d;
      word_count_q <= word_count_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;
  assign word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
